// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   state_e      : LSU FSM state encoding
//   *_DEF        : default address/data/memory-depth widths
//   LANE_LO/HI   : byte-lane select values (little-endian, addr[0])
package mem_stage_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned WORD_AW_DEF = 3;

  localparam logic LANE_LO = 1'b0;  // bits [7:0]
  localparam logic LANE_HI = 1'b1;  // bits [15:8]

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR
  } state_e;

endpackage

// File: rtl/mem_stage_lsu_byte_lane_unit.sv
// byte_lane_unit: combinational byte-lane datapath for the LSU.
//   lane_sel    in   selects byte lane (LANE_LO = [7:0], LANE_HI = [15:8])
//   load_byte   in   1 = byte load, 0 = word load
//   load_signed in   byte load: 1 = sign-extend, 0 = zero-extend
//   rd_word     in   word read from memory
//   st_byte     in   byte to insert for a byte store
//   load_data   out  extracted/extended load result
//   merge_word  out  rd_word with st_byte inserted into the selected lane
module byte_lane_unit
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              lane_sel,
  input  logic              load_byte,
  input  logic              load_signed,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [7:0]        st_byte,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_word
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = (lane_sel == LANE_HI) ? rd_word[15:8] : rd_word[7:0];

    if (load_byte) begin
      load_data = {{(DATA_W-8){load_signed & lane_byte[7]}}, lane_byte};
    end else begin
      load_data = rd_word;
    end

    if (lane_sel == LANE_HI) begin
      merge_word = {st_byte, rd_word[7:0]};
    end else begin
      merge_word = {rd_word[DATA_W-1:8], st_byte};
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store unit in front of the 8x16 data memory.
//   clk, rst_n          clock / async active-low reset
//   req_valid/ready     request handshake; ready only in IDLE
//   req_we/byte/signed  store / byte access / sign-extend byte load
//   req_addr, req_wdata byte address, store data (byte store uses [7:0])
//   rsp_valid           1-cycle completion pulse
//   rsp_rdata, rsp_err  load result (0 for stores/errors), error flag
//   mem_access_addr     word index (req_addr >> 1), upper bits zero
//   mem_write_data/en   write word / write strobe
//   mem_read            read strobe
//   mem_read_data       combinational read data from memory
// Byte stores run as read (RMW_RD) then write (RMW_WR) of the whole word.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned WORD_AW = WORD_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e              state_q, state_d;
  logic                accept;
  logic                req_err;

  logic                byte_q;
  logic                signed_q;
  logic [WORD_AW:0]    addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   merge_q;

  logic [DATA_W-1:0]   lane_load;
  logic [DATA_W-1:0]   lane_merge;

  assign accept  = req_valid & req_ready;
  assign req_err = (~req_byte & req_addr[0]) | (|req_addr[ADDR_W-1:WORD_AW+1]);

  byte_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .lane_sel    (addr_q[0]),
    .load_byte   (byte_q),
    .load_signed (signed_q),
    .rd_word     (mem_read_data),
    .st_byte     (wdata_q[7:0]),
    .load_data   (lane_load),
    .merge_word  (lane_merge)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; erroneous requests never leave IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !req_err) begin
          if (!req_we)       state_d = LOAD;
          else if (req_byte) state_d = RMW_RD;
          else               state_d = STORE;
        end
      end
      LOAD:    state_d = IDLE;
      STORE:   state_d = IDLE;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state and latched request
  always_comb begin
    req_ready       = (state_q == IDLE);
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    unique case (state_q)
      LOAD: begin
        mem_access_addr = ADDR_W'(addr_q[WORD_AW:1]);
        mem_read        = 1'b1;
      end
      STORE: begin
        mem_access_addr = ADDR_W'(addr_q[WORD_AW:1]);
        mem_write_data  = wdata_q;
        mem_write_en    = 1'b1;
      end
      RMW_RD: begin
        mem_access_addr = ADDR_W'(addr_q[WORD_AW:1]);
        mem_read        = 1'b1;
      end
      RMW_WR: begin
        mem_access_addr = ADDR_W'(addr_q[WORD_AW:1]);
        mem_write_data  = merge_q;
        mem_write_en    = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latch; only address bits inside the memory range are kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      byte_q   <= req_byte;
      signed_q <= req_signed;
      addr_q   <= req_addr[WORD_AW:0];
      wdata_q  <= req_wdata;
    end
  end

  // Merge register: read word with the store byte inserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merge_q <= '0;
    end else if (state_q == RMW_RD) begin
      merge_q <= lane_merge;
    end
  end

  // Response registers; rsp_rdata only changes when a response is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept && req_err) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end else begin
        unique case (state_q)
          LOAD: begin
            rsp_valid <= 1'b1;
            rsp_rdata <= lane_load;
            rsp_err   <= 1'b0;
          end
          STORE, RMW_WR: begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu with an 8x16 data memory model below it.
module tb_mem_stage_lsu;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(16), .DATA_W(16), .WORD_AW(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_byte        (req_byte),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );

  // Data memory: preloaded while mem_init_done=0, then synchronous write, async read
  localparam logic [15:0] INIT [8] = '{16'h0F00, 16'h1234, 16'h2222, 16'h3333,
                                       16'h4444, 16'h5555, 16'h6666, 16'h7777};
  logic [15:0] mem [8];
  logic        mem_init_done;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 8; i++) mem[i] <= INIT[i];
    end else if (mem_write_en) begin
      mem[mem_access_addr[2:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_access_addr[2:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;
  exp_t sb[$];

  int   errors = 0;
  int   checks = 0;
  logic rd_seen = 1'b0;
  logic wr_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each response
  initial begin
    logic        prev_valid;
    logic [15:0] last_rdata;
    exp_t        e;
    prev_valid = 1'b0;
    last_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("invariants {rd&wr, rsp_len>1, ready!=idle, addr_hi, rdata_hold}",
            {27'd0,
             mem_read & mem_write_en,
             rsp_valid & prev_valid,
             req_ready !== (dut.state_q == IDLE),
             |mem_access_addr[15:3],
             !rsp_valid && (rsp_rdata !== last_rdata)}, 32'd0);
        if (mem_read)     rd_seen = 1'b1;
        if (mem_write_en) wr_seen = 1'b1;
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected no response", cyc);
          end else begin
            e = sb.pop_front();
            chk({e.name, " rdata"}, rsp_rdata, e.rdata);
            chk({e.name, " err"}, rsp_err, e.err);
            chk({e.name, " latency"}, cyc, e.due);
          end
          last_rdata = rsp_rdata;
        end
        prev_valid = rsp_valid;
      end else begin
        prev_valid = 1'b0;
        last_rdata = '0;
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accept edge
  task automatic issue(input logic we, input logic byt, input logic sgn,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rd, input logic exp_err, input int lat,
                       input string nm, input logic push, output int acc);
    int n;
    req_we     = we;
    req_byte   = byt;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s accept_timeout: got req_ready=%b expected 1 within 20 cycles", nm, req_ready);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (push) sb.push_back(exp_t'{exp_rd, exp_err, acc + lat - 1, nm});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int a;
    int acc4 [4];
    int n;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_byte      = 1'b0;
    req_signed    = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    mem_init_done = 1'b0;
    repeat (2) @(negedge clk);
    mem_init_done = 1'b1;

    chk("reset req_ready", req_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_err", rsp_err, 0);
    chk("reset mem_outs", {mem_access_addr, mem_write_data}, 0);
    chk("reset mem_strobes", {mem_read, mem_write_en}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store / load; 0x00A6 lies outside the 16-byte range
    issue(1, 0, 0, 16'h0006, 16'hBEEF, 16'h0000, 0, 2, "t1 word_store", 1, a); gap(2);
    chk("t1 mem[3]", mem[3], 16'hBEEF);
    issue(0, 0, 0, 16'h0006, 16'h0000, 16'hBEEF, 0, 2, "t1 word_load", 1, a);  gap(2);
    issue(0, 0, 0, 16'h00A6, 16'h0000, 16'h0000, 1, 1, "t1 range_err", 1, a);  gap(2);

    // Byte store via read-modify-write, byte loads in both lanes
    issue(1, 1, 0, 16'h0003, 16'h00AB, 16'h0000, 0, 3, "t2 byte_store_hi", 1, a); gap(3);
    chk("t2 mem[1]", mem[1], 16'hAB34);
    issue(0, 1, 1, 16'h0003, 16'h0000, 16'hFFAB, 0, 2, "t2 sload_hi", 1, a);  gap(2);
    issue(0, 1, 0, 16'h0002, 16'h0000, 16'h0034, 0, 2, "t2 uload_lo", 1, a);  gap(2);
    issue(1, 1, 0, 16'h000F, 16'h55C3, 16'h0000, 0, 3, "t2 byte_store_top", 1, a); gap(3);
    chk("t2 mem[7]", mem[7], 16'hC377);
    issue(0, 1, 1, 16'h000E, 16'h0000, 16'h0077, 0, 2, "t2 sload_pos", 1, a); gap(2);
    issue(0, 1, 1, 16'h000F, 16'h0000, 16'hFFC3, 0, 2, "t2 sload_neg", 1, a); gap(2);

    // Errors must not touch memory
    rd_seen = 1'b0;
    wr_seen = 1'b0;
    issue(0, 0, 0, 16'h0005, 16'h0000, 16'h0000, 1, 1, "t3 misaligned", 1, a); gap(2);
    issue(1, 0, 0, 16'h0010, 16'hDEAD, 16'h0000, 1, 1, "t3 store_range", 1, a); gap(3);
    chk("t3 mem_read_seen", rd_seen, 0);
    chk("t3 mem_write_seen", wr_seen, 0);
    chk("t3 mem[0]", mem[0], 16'h0F00);

    // Back-to-back loads with req_valid held
    issue(0, 0, 0, 16'h0000, 16'h0000, 16'h0F00, 0, 2, "t4 load0", 1, acc4[0]);
    issue(0, 0, 0, 16'h0002, 16'h0000, 16'hAB34, 0, 2, "t4 load1", 1, acc4[1]);
    issue(0, 0, 0, 16'h0004, 16'h0000, 16'h2222, 0, 2, "t4 load2", 1, acc4[2]);
    issue(0, 0, 0, 16'h0006, 16'h0000, 16'hBEEF, 0, 2, "t4 load3", 1, acc4[3]);
    gap(4);
    for (int i = 0; i < 3; i++) chk($sformatf("t4 accept_spacing%0d", i), acc4[i+1] - acc4[i], 2);

    // Reset during RMW_RD aborts the byte store
    issue(1, 1, 0, 16'h0004, 16'h0099, 16'h0000, 0, 3, "t5 aborted", 0, a);
    chk("t5 in_rmw_rd mem_read", mem_read, 1);
    #2 rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("t5 async mem_strobes", {mem_read, mem_write_en}, 0);
    chk("t5 async mem_access_addr", mem_access_addr, 0);
    chk("t5 async rsp_valid", rsp_valid, 0);
    chk("t5 async rsp_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    chk("t5 mem[2] unchanged", mem[2], 16'h2222);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5 req_ready after reset", req_ready, 1);
    chk("t5 mem[2] after release", mem[2], 16'h2222);
    issue(0, 0, 0, 16'h0004, 16'h0000, 16'h2222, 0, 2, "t5 load_after", 1, a); gap(3);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard drained (pending)", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
